// File: rtl/check_min_search.sv
// check_min_search: min-sum LDPC check-node reducer.
// Streams one (sign, magnitude) pair per cycle for a parity-check row and
// produces the two smallest magnitudes (offset corrected), the index of the
// smallest, the sign product and the per-edge sign vector.
module check_min_search #(
    parameter int MAG_W  = 8,
    parameter int DEG    = 32,
    parameter int IDX_W  = 5,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic             in_sign,
    input  logic [MAG_W-1:0] in_mag,
    output logic             busy,
    output logic             out_valid,
    output logic [MAG_W-1:0] min1,
    output logic [MAG_W-1:0] min2,
    output logic [IDX_W-1:0] min1_idx,
    output logic             sign_prod,
    output logic [DEG-1:0]   sign_vec,
    output logic             row_abort
);

    typedef enum logic [0:0] {IDLE, ACC} state_t;

    localparam logic [MAG_W-1:0] OFF  = MAG_W'(OFFSET);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEG - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic [MAG_W-1:0] m1, m1_nxt;
    logic [MAG_W-1:0] m2, m2_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             sp, sp_nxt;
    logic [DEG-1:0]   sv, sv_nxt;
    logic             last_edge;
    logic             abort;

    // Offset-min-sum correction, clamped at zero instead of wrapping.
    function automatic logic [MAG_W-1:0] sat_off(input logic [MAG_W-1:0] v);
        return (v > OFF) ? (v - OFF) : '0;
    endfunction

    assign busy = (state == ACC);

    // Next-state and accumulator update, including the edge being accepted now.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        m1_nxt    = m1;
        m2_nxt    = m2;
        idx_nxt   = idx;
        sp_nxt    = sp;
        sv_nxt    = sv;
        last_edge = 1'b0;
        abort     = 1'b0;
        if (in_valid && in_start) begin
            // A start always opens a fresh row; in ACC it discards the partial one.
            state_nxt = ACC;
            cnt_nxt   = IDX_W'(1);
            m1_nxt    = in_mag;
            m2_nxt    = '1;
            idx_nxt   = '0;
            sp_nxt    = in_sign;
            sv_nxt    = '0;
            sv_nxt[0] = in_sign;
            abort     = (state == ACC);
        end else if (in_valid && (state == ACC)) begin
            // Strict compare so equal magnitudes fall to m2 and idx keeps the earliest.
            if (in_mag < m1) begin
                m2_nxt  = m1;
                m1_nxt  = in_mag;
                idx_nxt = cnt;
            end else if (in_mag < m2) begin
                m2_nxt = in_mag;
            end
            sp_nxt = sp ^ in_sign;
            for (int k = 0; k < DEG; k++) begin
                if (cnt == IDX_W'(k)) begin
                    sv_nxt[k] = in_sign;
                end
            end
            if (cnt == LAST) begin
                last_edge = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + IDX_W'(1);
            end
        end
    end

    // Row accumulator and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            m1    <= '0;
            m2    <= '0;
            idx   <= '0;
            sp    <= 1'b0;
            sv    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            m1    <= m1_nxt;
            m2    <= m2_nxt;
            idx   <= idx_nxt;
            sp    <= sp_nxt;
            sv    <= sv_nxt;
        end
    end

    // Result registers capture on the final edge and hold until the next row completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            row_abort <= 1'b0;
            min1      <= '0;
            min2      <= '0;
            min1_idx  <= '0;
            sign_prod <= 1'b0;
            sign_vec  <= '0;
        end else begin
            out_valid <= last_edge;
            row_abort <= abort;
            if (last_edge) begin
                min1      <= sat_off(m1_nxt);
                min2      <= sat_off(m2_nxt);
                min1_idx  <= idx_nxt;
                sign_prod <= sp_nxt;
                sign_vec  <= sv_nxt;
            end
        end
    end

endmodule

// File: tb/tb_check_min_search.sv
// tb_check_min_search: directed plus randomized rows for check_min_search,
// run on two instances (offset 0 and offset 2) sharing one input stream.
`timescale 1ns/1ps
module tb_check_min_search;

    typedef int row_t [4];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_start;
    logic       in_sign;
    logic [7:0] in_mag;

    logic       busy_a, out_valid_a, sign_prod_a, row_abort_a;
    logic [7:0] min1_a, min2_a;
    logic [1:0] idx_a;
    logic [3:0] sign_vec_a;

    logic       busy_b, out_valid_b, sign_prod_b, row_abort_b;
    logic [7:0] min1_b, min2_b;
    logic [1:0] idx_b;
    logic [3:0] sign_vec_b;

    int checks   = 0;
    int failures = 0;

    check_min_search #(.MAG_W(8), .DEG(4), .IDX_W(2), .OFFSET(0)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .busy      (busy_a),
        .out_valid (out_valid_a),
        .min1      (min1_a),
        .min2      (min2_a),
        .min1_idx  (idx_a),
        .sign_prod (sign_prod_a),
        .sign_vec  (sign_vec_a),
        .row_abort (row_abort_a)
    );

    check_min_search #(.MAG_W(8), .DEG(4), .IDX_W(2), .OFFSET(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .busy      (busy_b),
        .out_valid (out_valid_b),
        .min1      (min1_b),
        .min2      (min2_b),
        .min1_idx  (idx_b),
        .sign_prod (sign_prod_b),
        .sign_vec  (sign_vec_b),
        .row_abort (row_abort_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int off);
        return (v > off) ? v - off : 0;
    endfunction

    // One clock of input, outputs sampled 1 ns after the edge.
    task automatic step(input bit v, input bit st, input bit sg, input int mag);
        in_valid = v;
        in_start = st;
        in_sign  = sg;
        in_mag   = 8'(mag);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_sign  = 1'b0;
        in_mag   = 8'd0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy_a"}, 32'(busy_a), 0);
        check({tag, ".ov_a"}, 32'(out_valid_a), 0);
        check({tag, ".min1_a"}, 32'(min1_a), 0);
        check({tag, ".min2_a"}, 32'(min2_a), 0);
        check({tag, ".idx_a"}, 32'(idx_a), 0);
        check({tag, ".sp_a"}, 32'(sign_prod_a), 0);
        check({tag, ".sv_a"}, 32'(sign_vec_a), 0);
        check({tag, ".abort_a"}, 32'(row_abort_a), 0);
        check({tag, ".busy_b"}, 32'(busy_b), 0);
        check({tag, ".ov_b"}, 32'(out_valid_b), 0);
        check({tag, ".min1_b"}, 32'(min1_b), 0);
        check({tag, ".min2_b"}, 32'(min2_b), 0);
        check({tag, ".sv_b"}, 32'(sign_vec_b), 0);
    endtask

    // Reference: sort the row's magnitudes; min1/min2 are the two smallest
    // values, min1_idx the first position holding the smallest.
    task automatic check_row(input string tag, input row_t m, input row_t s);
        int q[$];
        int ix;
        int sp;
        int sv;
        for (int i = 0; i < 4; i++) q.push_back(m[i]);
        q.sort();
        ix = -1;
        for (int i = 0; i < 4; i++) if (ix < 0 && m[i] == q[0]) ix = i;
        sp = 0;
        sv = 0;
        for (int i = 0; i < 4; i++) begin
            sp = sp ^ s[i];
            sv = sv | (s[i] << i);
        end
        check({tag, ".ov_a"}, 32'(out_valid_a), 1);
        check({tag, ".min1_a"}, 32'(min1_a), sat(q[0], 0));
        check({tag, ".min2_a"}, 32'(min2_a), sat(q[1], 0));
        check({tag, ".idx_a"}, 32'(idx_a), ix);
        check({tag, ".sp_a"}, 32'(sign_prod_a), sp);
        check({tag, ".sv_a"}, 32'(sign_vec_a), sv);
        check({tag, ".ov_b"}, 32'(out_valid_b), 1);
        check({tag, ".min1_b"}, 32'(min1_b), sat(q[0], 2));
        check({tag, ".min2_b"}, 32'(min2_b), sat(q[1], 2));
        check({tag, ".idx_b"}, 32'(idx_b), ix);
    endtask

    task automatic apply_stimulus(input string tag, input row_t m, input row_t s, input int bubble_max);
        int nb;
        for (int k = 0; k < 4; k++) begin
            if (k > 0 && bubble_max > 0) begin
                nb = $urandom_range(0, bubble_max);
                repeat (nb) begin
                    step(1'b0, 1'b0, 1'b0, 0);
                    check({tag, ".bubble_busy"}, 32'(busy_a), 1);
                    check({tag, ".bubble_ov"}, 32'(out_valid_a), 0);
                end
            end
            step(1'b1, k == 0, s[k] != 0, m[k]);
            if (k < 3) begin
                check({tag, ".mid_ov"}, 32'(out_valid_a), 0);
                check({tag, ".mid_busy"}, 32'(busy_a), 1);
                check({tag, ".mid_abort"}, 32'(row_abort_a), 0);
            end
        end
        check_row(tag, m, s);
    endtask

    initial begin
        row_t m;
        row_t s;
        int   mode;
        int   base;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_sign  = 1'b0;
        in_mag   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stray valid without start in IDLE is ignored.
        step(1'b1, 1'b0, 1'b1, 4);
        check("idle_ignore.busy", 32'(busy_a), 0);
        check("idle_ignore.ov", 32'(out_valid_a), 0);

        // Basic row, then hold check while idle.
        m = '{7, 3, 9, 5};
        s = '{0, 1, 1, 1};
        apply_stimulus("basic", m, s, 0);
        check("basic.sv_const", 32'(sign_vec_a), 32'hE);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        check("hold.ov", 32'(out_valid_a), 0);
        check("hold.min1", 32'(min1_a), 3);
        check("hold.idx", 32'(idx_a), 1);

        // Offset saturation and tie handling.
        m = '{1, 4, 4, 6};
        s = '{0, 0, 1, 0};
        apply_stimulus("offset_sat", m, s, 0);
        m = '{5, 2, 2, 8};
        s = '{1, 1, 0, 0};
        apply_stimulus("offset_tie", m, s, 0);

        // Back-to-back rows: the second start lands in the out_valid cycle.
        m = '{8, 6, 4, 2};
        s = '{0, 0, 0, 1};
        apply_stimulus("b2b_a", m, s, 0);
        m = '{1, 1, 3, 3};
        s = '{1, 0, 1, 0};
        apply_stimulus("b2b_b", m, s, 0);

        // Bubble pattern 1,0,0,1,1,0,1.
        step(1'b1, 1'b1, 1'b0, 10);
        step(1'b0, 1'b0, 1'b0, 0);
        check("bubble.busy1", 32'(busy_a), 1);
        step(1'b0, 1'b0, 1'b0, 0);
        check("bubble.busy2", 32'(busy_a), 1);
        step(1'b1, 1'b0, 1'b1, 20);
        step(1'b1, 1'b0, 1'b0, 5);
        step(1'b0, 1'b0, 1'b0, 0);
        check("bubble.busy3", 32'(busy_a), 1);
        check("bubble.ov", 32'(out_valid_a), 0);
        step(1'b1, 1'b0, 1'b1, 15);
        m = '{10, 20, 5, 15};
        s = '{0, 1, 0, 1};
        check_row("bubble", m, s);

        // Abort: two edges, then a restart carrying 9,8,7,6.
        step(1'b1, 1'b1, 1'b1, 11);
        step(1'b1, 1'b0, 1'b1, 12);
        check("abort.pre", 32'(row_abort_a), 0);
        step(1'b1, 1'b1, 1'b1, 9);
        check("abort.pulse_a", 32'(row_abort_a), 1);
        check("abort.pulse_b", 32'(row_abort_b), 1);
        check("abort.busy", 32'(busy_a), 1);
        step(1'b1, 1'b0, 1'b0, 8);
        check("abort.once", 32'(row_abort_a), 0);
        check("abort.no_ov", 32'(out_valid_a), 0);
        step(1'b1, 1'b0, 1'b0, 7);
        check("abort.no_ov2", 32'(out_valid_a), 0);
        step(1'b1, 1'b0, 1'b0, 6);
        m = '{9, 8, 7, 6};
        s = '{1, 0, 0, 0};
        check_row("abort", m, s);
        check("abort.after", 32'(row_abort_a), 0);

        // Mid-row asynchronous reset clears outputs immediately.
        step(1'b1, 1'b1, 1'b0, 50);
        step(1'b1, 1'b0, 1'b1, 40);
        #2 rst_n = 1'b0;
        #1;
        check_zero("midreset");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 3);
            check("postreset.ov", 32'(out_valid_a), 0);
            check("postreset.busy", 32'(busy_a), 0);
        end

        // Randomized rows with ties, all-equal and all-ones patterns and bubbles.
        for (int r = 0; r < 30; r++) begin
            mode = $urandom_range(0, 3);
            base = $urandom_range(0, 255);
            for (int i = 0; i < 4; i++) begin
                case (mode)
                    0:       m[i] = $urandom_range(0, 255);
                    1:       m[i] = $urandom_range(0, 3);
                    2:       m[i] = base;
                    default: m[i] = 255;
                endcase
                s[i] = $urandom_range(0, 1);
            end
            apply_stimulus($sformatf("rnd%0d", r), m, s, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/check_min_search.md
Name: check_min_search

Overview:
- Check-node magnitude/sign reducer for the min-sum LDPC decoder.
- Sits directly downstream of the per-edge q-r subtract/abs stage. Consumes one (sign, |q-r|) pair per cycle for one parity-check row.
- Produces per row: smallest magnitude (min1), second smallest (min2), the edge index of min1, the XOR of all signs, and the per-edge sign vector.
- The check-to-variable message update stage uses these outputs.

Parameters:
- MAG_W, 8, magnitude width (iniBW+exBW).
- DEG, 32, check-node degree (edges per row), 2..64.
- IDX_W, 5, edge index width; must satisfy 2^IDX_W >= DEG.
- OFFSET, 0, offset-min-sum correction subtracted from min1/min2 at output, saturating at 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  edge data valid this cycle
- in_start  in  1  qualifies the first edge of a row; meaningful only with in_valid
- in_sign  in  1  sign of q-r for this edge (1 = negative)
- in_mag  in  MAG_W  magnitude |q-r|, unsigned
- busy  out  1  row accumulation in progress
- out_valid  out  1  one-cycle pulse: row results valid
- min1  out  MAG_W  offset-corrected smallest magnitude
- min2  out  MAG_W  offset-corrected second smallest magnitude
- min1_idx  out  IDX_W  edge index (0-based arrival order) of min1
- sign_prod  out  1  XOR of all DEG edge signs
- sign_vec  out  DEG  bit k = sign of edge k
- row_abort  out  1  one-cycle pulse: a row was restarted before completion

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; busy, out_valid and row_abort = 0; min1, min2, min1_idx, sign_prod and sign_vec = 0; internal count = 0.
- States:
  - IDLE: in_valid&in_start -> ACC. Edge 0 is loaded: m1=in_mag, m2=all-ones, idx=0, sp=in_sign, sv[0]=in_sign, cnt=1.
  - IDLE: in_valid without in_start is ignored.
  - ACC: each in_valid updates the accumulators and increments cnt.
  - ACC: when the accepted edge has cnt==DEG-1, results register on that edge, out_valid pulses the next cycle, and the FSM returns to IDLE.
- Accumulator update for magnitude v at index cnt:
  - v < m1: m2<=m1, m1<=v, idx<=cnt.
  - else v < m2: m2<=v.
  - else: no change.
  - Ties (v==m1) go to m2; min1_idx keeps the earliest index.
- Signs: sp<=sp^in_sign; sv[cnt]<=in_sign.
- Output registers:
  - min1 = m1>OFFSET ? m1-OFFSET : 0; min2 is computed the same way.
  - The final edge's contribution is included, computed combinationally before the output register.
  - Outputs hold until the next out_valid.
- Latency: out_valid is high exactly 1 cycle after the DEG-th edge is accepted.
- busy is 1 from the cycle after the first edge until the cycle out_valid rises.
- in_valid low cycles (bubbles) are allowed mid-row: no state change, cnt holds.
- Back-to-back rows: in_valid&in_start may arrive in the cycle out_valid is high (FSM already IDLE) and must be accepted with zero gap.
- in_valid&in_start while in ACC: the partial row is discarded and row_abort pulses the next cycle. The edge is loaded as edge 0 of a new row; out_valid does not pulse for the aborted row.
- A mid-row assertion of rst_n clears everything immediately; no out_valid for that row.
- DEG edges with all magnitudes equal: min1=min2=that value (before offset), min1_idx=0.
- All magnitudes at maximum (all-ones): min1=min2=2^MAG_W-1 (before offset). The m2 initial value is not distinguishable, which is correct.

Test Plan:
- Use DEG=4, OFFSET=0. Feed mags 7,3,9,5 with signs 0,1,1,1 -> 1 cycle after the last edge: out_valid=1, min1=3, min2=5, min1_idx=1, sign_prod=1, sign_vec=4'b1110.
- Use DEG=4, OFFSET=2. Feed mags 1,4,4,6 -> min1=0 (saturated), min2=2, min1_idx=0. Feed mags 5,2,2,8 -> min1=0, min2=0, min1_idx=1 (tie kept earliest).
- Two rows back-to-back: row B's start coincides with row A's out_valid. Row A = 8,6,4,2; row B = 1,1,3,3 -> A: min1=2, min2=4, idx=3; B out_valid 4 cycles later: min1=1, min2=1, idx=0.
- Bubbles: in_valid pattern 1,0,0,1,1,0,1 carrying mags 10,20,5,15 -> out_valid 1 cycle after the 4th valid; min1=5, min2=10, idx=2; busy high throughout.
- Abort: start a row, send 2 edges, then in_start again followed by mags 9,8,7,6 -> row_abort pulses once; only one out_valid: min1=6, min2=7, idx=3.
- Assert rst_n low after 2 edges -> all outputs 0 immediately. A subsequent in_valid without in_start is ignored; no out_valid.
